// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  // Fetch request state: nothing in flight, request presented, or awaiting data.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  // A buffered fetch is {instr, pc4}.
  localparam int ENTRY_W = 64;

  // Word-align a fetch address by clearing the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instr, pc4} entries.
// clear wins over push/pop; push and pop may occur together.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [ENTRY_W-1:0]         din,
  output logic [ENTRY_W-1:0]         dout,
  output logic                       empty,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [BUF_DEPTH];
  logic [ENTRY_W-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full;
  logic               push_ok;
  logic               pop_ok;

  assign full  = (count_q == CNT_W'(BUF_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; a push into a full buffer is refused.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory one word at
// a time and feeds the IF/ID register from a small fetch buffer.
//
// Memory handshake: a request transfers on a posedge where imem_req_valid and
// imem_req_ready are both high; imem_req_valid and imem_addr stay stable until
// then. The matching response is the first imem_rsp_valid sampled in WAIT,
// never in the same cycle as its request handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic [31:0]  instr,
  output logic [31:0]  PCPlusFour,
  output logic         if_id_en,
  output logic         if_id_flush,
  output fetch_state_e dbg_state
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               kill_q, kill_d;

  logic               buf_push;
  logic               buf_pop;
  logic               buf_clear;
  logic [ENTRY_W-1:0] buf_din;
  logic [ENTRY_W-1:0] buf_dout;
  logic               buf_empty;
  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W:0]     cnt_next;
  logic               credit;
  logic               rsp_in_wait;
  logic [31:0]        redir_addr;
  logic [31:0]        next_fetch;

  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (buf_push),
    .pop  (buf_pop),
    .clear(buf_clear),
    .din  (buf_din),
    .dout (buf_dout),
    .empty(buf_empty),
    .count(buf_count)
  );

  // Buffer control and the credit check: a new request is only issued when
  // the slot its response will need is guaranteed free after this edge.
  always_comb begin
    redir_addr  = align_word(redirect_target);
    rsp_in_wait = (state_q == ST_WAIT) & imem_rsp_valid;
    buf_clear   = redirect_valid;
    buf_pop     = ~stall & ~redirect_valid & ~buf_empty;
    buf_push    = rsp_in_wait & ~kill_q & ~redirect_valid;
    buf_din     = {imem_rsp_data, req_addr_q + PC_INC};
    if (buf_clear) begin
      cnt_next = '0;
    end else begin
      case ({buf_push, buf_pop})
        2'b10:   cnt_next = {1'b0, buf_count} + 1'b1;
        2'b01:   cnt_next = {1'b0, buf_count} - 1'b1;
        default: cnt_next = {1'b0, buf_count};
      endcase
    end
    credit = (cnt_next < (CNT_W+1)'(BUF_DEPTH));
  end

  // Next-state logic: request sequencing, PC advance, redirect and kill.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    next_fetch = redirect_valid ? redir_addr : pc_q;
    if (redirect_valid) begin
      pc_d = redir_addr;
    end
    case (state_q)
      ST_IDLE: begin
        if (credit) begin
          state_d    = ST_REQ;
          req_addr_d = next_fetch;
        end
      end
      ST_REQ: begin
        // A redirect cannot retract a presented request, so its data is marked stale.
        if (redirect_valid) begin
          kill_d = 1'b1;
        end
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          // A stale request must not advance the redirected PC.
          if (!redirect_valid && !kill_q) begin
            pc_d = pc_q + PC_INC;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (credit) begin
            state_d    = ST_REQ;
            req_addr_d = next_fetch;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  // Output drive; everything is forced to its idle value while in reset.
  always_comb begin
    imem_req_valid = rst & (state_q == ST_REQ);
    imem_addr      = req_addr_q;
    instr          = (rst & ~buf_empty) ? buf_dout[63:32] : NOP_INSTR;
    PCPlusFour     = (rst & ~buf_empty) ? buf_dout[31:0] : 32'h0;
    if_id_en       = rst & ~stall;
    if_id_flush    = ~rst | redirect_valid | (~stall & buf_empty);
    dbg_state      = state_q;
  end

endmodule
